prog_seq_counter: RTL and testbench
===================================

PROG_SEQ_COUNTER -- requirements
Module: prog_seq_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each sequence code and of q.
REQ-002 Parameter IDX_W, default 4: index width; table depth DEPTH = 2^IDX_W entries.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port clear  input  1: reset, asynchronous and active-low.
REQ-005 Port wr_en  input  1: table write strobe.
REQ-006 Port wr_addr  input  IDX_W: table write address.
REQ-007 Port wr_data  input  WIDTH: table write data.
REQ-008 Port last  input  IDX_W: index of last valid entry; sequence length = last+1.
REQ-009 Port start  input  1: restart request, sampled each edge.
REQ-010 Port en  input  1: step enable.
REQ-011 Port dir  input  1: 0 = forward (idx up), 1 = reverse (idx down).
REQ-012 Port one_shot  input  1: 1 = stop at end of sequence; 0 = wrap continuously.
REQ-013 Port q  output  WIDTH: current code = table[idx].
REQ-014 Port idx  output  IDX_W: current table index, registered.
REQ-015 Port tc  output  1: terminal count, combinational.
REQ-016 Port done  output  1: one-shot completed, registered, sticky.

Function
REQ-017 Block SHALL hold a DEPTH x WIDTH register table; wr_en=1 SHALL write wr_data to table[wr_addr] on the edge, in any state.
REQ-018 q SHALL equal table[idx] continuously; a write to the entry at the current idx SHALL appear on q the cycle after the write edge.
REQ-019 FSM states SHALL be IDLE, RUN, DONE.
REQ-020 start=1 in any state SHALL, on the edge, set idx = 0 (dir=0) or last (dir=1), clear done, enter RUN; start SHALL take priority over en.
REQ-021 IDLE and DONE SHALL hold idx when start=0, regardless of en.
REQ-022 RUN with en=0 SHALL hold idx.
REQ-023 End index SHALL be: forward, any idx >= last; reverse, idx = 0.
REQ-024 RUN, en=1, not at end: idx SHALL step +1 (forward) or -1 (reverse) per edge.
REQ-025 RUN, en=1, at end, one_shot=0: idx SHALL wrap to 0 (forward) or last (reverse) and stay in RUN.
REQ-026 RUN, en=1, at end, one_shot=1: idx SHALL hold, done SHALL go to 1, FSM SHALL enter DONE.
REQ-027 tc SHALL be 1 exactly when state = RUN, en = 1 and idx is at end index.
REQ-028 dir, last and one_shot changes SHALL take effect on the next step with no restart; forward with idx > last SHALL wrap to 0 on the next step.
REQ-029 last = 0 SHALL give a one-entry sequence: tc=1 every enabled RUN cycle, idx stays 0.
REQ-030 Index arithmetic SHALL be modulo 2^IDX_W; no out-of-range table access.

Reset
REQ-031 clear=0 SHALL immediately, without clk, force state IDLE, idx=0, done=0, table[i] = i mod 2^WIDTH for every i.
REQ-032 Hence q = 0 and tc = 0 during and after reset until the first start.
REQ-033 Reset SHALL take precedence over start, en and wr_en; deassertion SHALL be synchronised by the integrator, not the block.

Verification
REQ-034 Reset: clear=0 with clk stopped mid-RUN -> idx=0, q=0, done=0 at once; reading idx 5 after start shows q=5.
REQ-035 Default forward wrap: last=3, dir=0, one_shot=0, start then en=1 -> q 0,1,2,3,0,1; tc=1 only in idx-3 cycles.
REQ-036 Loaded sequence: write {9,4,12,6} to 0..3, last=3, start, en=1 -> q 9,4,12,6,9.
REQ-037 Reverse one-shot: same table, dir=1, one_shot=1, start -> q 6,12,4,9, then done=1, q holds 9 while en=1; next start clears done, q=6.
REQ-038 Hold/restart: en=0 for 3 cycles at idx 2 -> idx stays 2; start with en=1 same edge -> idx 0, no step.
REQ-039 Live edits: during RUN at idx 2 write table[2]=15 -> q=15 next cycle; set last=1 -> next step idx 0.

Source files
------------

// File: rtl/prog_seq_counter.sv
// Programmable sequence counter: walks a writable code table forward or reverse,
// either wrapping continuously or stopping once in one-shot mode.
module prog_seq_counter #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] last,
  input  logic             start,
  input  logic             en,
  input  logic             dir,
  input  logic             one_shot,
  output logic [WIDTH-1:0] q,
  output logic [IDX_W-1:0] idx,
  output logic             tc,
  output logic             done
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic             at_end;

  // Reset loads an identity table so a fresh block counts 0,1,2,... untouched.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= WIDTH'(i);
    end else if (wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  // Forward uses >= so a shrunk 'last' below the current idx still wraps.
  assign at_end = dir ? (idx_q == '0) : (idx_q >= last);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else if (start) begin
      state_q <= RUN;
      idx_q   <= dir ? last : '0;
      done_q  <= 1'b0;
    end else if (state_q == RUN && en) begin
      if (!at_end) begin
        idx_q <= dir ? idx_q - IDX_ONE : idx_q + IDX_ONE;
      end else if (!one_shot) begin
        idx_q <= dir ? last : '0;
      end else begin
        state_q <= DONE;
        done_q  <= 1'b1;
      end
    end
  end

  assign q    = tbl_q[idx_q];
  assign idx  = idx_q;
  assign tc   = (state_q == RUN) && en && at_end;
  assign done = done_q;

endmodule

// File: tb/tb_prog_seq_counter.sv
// Bench for prog_seq_counter: directed scenarios plus random traffic, all
// compared against a behavioural sequence model.
module tb_prog_seq_counter;
  localparam int WIDTH = 4;
  localparam int IDX_W = 4;
  localparam int DEPTH = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             clear;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [IDX_W-1:0] last;
  logic             start, en, dir, one_shot;
  logic [WIDTH-1:0] q;
  logic [IDX_W-1:0] idx;
  logic             tc, done;

  int checks = 0;
  int errors = 0;

  // model: code table, position, whether stepping, sticky completion flag
  int m_tbl [DEPTH];
  int m_idx;
  bit m_run;
  bit m_done;

  prog_seq_counter #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last(last), .start(start), .en(en), .dir(dir), .one_shot(one_shot),
    .q(q), .idx(idx), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % (1 << WIDTH);
    m_idx  = 0;
    m_run  = 0;
    m_done = 0;
  endtask

  function automatic bit m_at_end();
    return dir ? (m_idx == 0) : (m_idx >= int'(last));
  endfunction

  // One clock: compare at settle time, then advance the model on the edge.
  task automatic cyc();
    #1;
    chk("idx", 32'(idx), 32'(m_idx));
    chk("q", 32'(q), 32'(m_tbl[m_idx]));
    chk("done", 32'(done), 32'(m_done));
    chk("tc", 32'(tc), 32'(m_run && en && m_at_end()));
    @(posedge clk);
    if (start) begin
      m_idx = dir ? int'(last) : 0;
      m_run = 1; m_done = 0;
    end else if (m_run && en) begin
      if (!m_at_end()) m_idx = dir ? (m_idx + DEPTH - 1) % DEPTH : (m_idx + 1) % DEPTH;
      else if (!one_shot) m_idx = dir ? int'(last) : 0;
      else begin m_run = 0; m_done = 1; end
    end
    if (wr_en) m_tbl[wr_addr] = int'(wr_data);
    @(negedge clk);
  endtask

  task automatic drv(input bit st, input bit e, input bit d, input bit os);
    start = st; en = e; dir = d; one_shot = os; wr_en = 0;
  endtask

  task automatic wr(input int a, input int v);
    drv(0, 0, dir, one_shot);
    wr_en = 1; wr_addr = IDX_W'(a); wr_data = WIDTH'(v);
    cyc();
    wr_en = 0;
  endtask

  int exp_fwd [6] = '{0, 1, 2, 3, 0, 1};
  int exp_ld  [5] = '{9, 4, 12, 6, 9};
  int exp_rev [4] = '{6, 12, 4, 9};

  initial begin
    clear = 0; wr_en = 0; wr_addr = '0; wr_data = '0; last = '0;
    start = 0; en = 0; dir = 0; one_shot = 0;
    m_reset();
    #12;
    chk("rst_idx", 32'(idx), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_tc", 32'(tc), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk); clear = 1;
    // tc must stay low before the first start even with en high
    drv(0, 1, 0, 0); last = 4'd3;
    repeat (2) cyc();

    // run to idx 5, then asynchronous clear between edges
    last = 4'd7;
    drv(1, 1, 0, 0); cyc();
    drv(0, 1, 0, 0); repeat (5) cyc();
    chk("q_at5", 32'(q), 5);
    #2 clear = 0;
    #1;
    chk("aclr_idx", 32'(idx), 0);
    chk("aclr_q", 32'(q), 0);
    chk("aclr_done", 32'(done), 0);
    m_reset();
    @(negedge clk); clear = 1;

    // default forward wrap
    last = 4'd3;
    drv(1, 1, 0, 0); cyc();
    drv(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      chk("fwd_q", 32'(q), 32'(exp_fwd[k]));
      chk("fwd_tc", 32'(tc), 32'(k == 3));
      cyc();
    end

    // loaded sequence
    wr(0, 9); wr(1, 4); wr(2, 12); wr(3, 6);
    drv(1, 1, 0, 0); cyc();
    drv(0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("ld_q", 32'(q), 32'(exp_ld[k]));
      cyc();
    end

    // reverse one-shot
    drv(1, 1, 1, 1); cyc();
    drv(0, 1, 1, 1);
    for (int k = 0; k < 4; k++) begin
      chk("rev_q", 32'(q), 32'(exp_rev[k]));
      cyc();
    end
    chk("rev_done", 32'(done), 1);
    repeat (3) cyc();
    chk("rev_hold_q", 32'(q), 9);
    drv(1, 1, 1, 1); cyc();
    chk("rev_restart_done", 32'(done), 0);
    chk("rev_restart_q", 32'(q), 6);

    // hold and restart
    drv(1, 1, 0, 0); cyc();
    drv(0, 1, 0, 0); repeat (2) cyc();
    drv(0, 0, 0, 0); repeat (3) cyc();
    chk("hold_idx", 32'(idx), 2);
    drv(1, 1, 0, 0); cyc();
    chk("restart_idx", 32'(idx), 0);

    // live edits
    drv(0, 1, 0, 0); repeat (2) cyc();
    wr(2, 15);
    chk("live_q", 32'(q), 15);
    last = 4'd1;
    drv(0, 1, 0, 0); cyc();
    chk("live_last_idx", 32'(idx), 0);

    // one-entry sequence
    last = 4'd0;
    drv(1, 1, 0, 0); cyc();
    drv(0, 1, 0, 0);
    repeat (3) begin
      chk("one_tc", 32'(tc), 1);
      cyc();
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      start    = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      dir      = ($urandom_range(0, 7) == 0) ? ~dir : dir;
      one_shot = ($urandom_range(0, 3) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = IDX_W'($urandom);
      wr_data  = WIDTH'($urandom);
      if ($urandom_range(0, 15) == 0) last = IDX_W'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
